// File: rtl/fetch_unit.sv
// RISC-V instruction fetch stage: PC, imem req/rvalid handshake, IR and field decode.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned branch targets into a HALT state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_VALID, S_HALT} state_e;
`else
    typedef enum logic [1:0] {S_REQ, S_VALID} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] cnt_q, cnt_d;
    logic        accept;

    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = (state_q == S_VALID) && instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign misaligned  = PCSrc && (PCTarget[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (accept) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d = PCSrc ? PCTarget : pc_plus4;
                    end
`else
                    // Low target bits are dropped: fetch stays word-aligned
                    pc_d = PCSrc ? (PCTarget & 32'hFFFF_FFFC)
                                 : pc_plus4;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            cnt_q   <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Request drops the moment reset asserts so an in-flight fetch is abandoned
    assign imem_req    = (state_q == S_REQ) && !rst;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);

    assign instr       = ir_q;
    assign pc          = pc_q;
    assign fetch_count = cnt_q;
    assign opcode      = ir_q[6:0];
    assign rd          = ir_q[11:7];
    assign funct3      = ir_q[14:12];
    assign rs1         = ir_q[19:15];
    assign rs2         = ir_q[24:20];
    assign funct7      = ir_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus randomized
// transactions against a transaction-level model of PC/count/IR.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_ir;
    logic        m_fault;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCSrc(PCSrc), .PCTarget(PCTarget),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .fetch_count(fetch_count), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag);
        check({tag, ".req"}, 32'(imem_req), 32'd1);
        check({tag, ".addr"}, imem_addr, m_pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".cnt"}, fetch_count, m_cnt);
    endtask

    task automatic chk_valid(input string tag);
        check({tag, ".req"}, 32'(imem_req), 32'd0);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".instr"}, instr, m_ir);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".cnt"}, fetch_count, m_cnt);
        check({tag, ".opc"}, 32'(opcode), 32'(m_ir[6:0]));
        check({tag, ".rd"}, 32'(rd), 32'(m_ir[11:7]));
        check({tag, ".f3"}, 32'(funct3), 32'(m_ir[14:12]));
        check({tag, ".rs1"}, 32'(rs1), 32'(m_ir[19:15]));
        check({tag, ".rs2"}, 32'(rs2), 32'(m_ir[24:20]));
        check({tag, ".f7"}, 32'(funct7), 32'(m_ir[31:25]));
        check({tag, ".flt"}, 32'(fetch_fault), 32'(m_fault));
    endtask

    // One instruction: wait states, response, stalls, accept.
    task automatic do_fetch(input string tag, input int wait_n,
                            input logic [31:0] word, input int stall_n,
                            input logic src, input logic [31:0] tgt);
        for (int i = 0; i < wait_n; i++) begin
            chk_req({tag, ".wait"});
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom);
            step();
        end
        chk_req({tag, ".rsp"});
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        instr_ready = 1'($urandom);
        step();
        m_ir = word;
        for (int i = 0; i < stall_n; i++) begin
            chk_valid({tag, ".stall"});
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            instr_ready = 1'b0;
            PCSrc       = 1'($urandom);
            PCTarget    = $urandom;
            step();
        end
        chk_valid({tag, ".acc"});
        imem_rvalid = 1'($urandom);
        imem_rdata  = $urandom;
        instr_ready = 1'b1;
        PCSrc       = src;
        PCTarget    = tgt;
        step();
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        PCSrc       = 1'($urandom);
        PCTarget    = $urandom;
        m_cnt = m_cnt + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (src && tgt[1:0] != 2'b00)
            m_fault = 1'b1;
        else
            m_pc = src ? tgt : m_pc + 32'd4;
`else
        m_pc = src ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
`endif
    endtask

    initial begin
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = 32'd0;
        m_pc    = 32'd0;
        m_cnt   = 32'd0;
        m_ir    = 32'h0000_0013;
        m_fault = 1'b0;

        repeat (3) step();
        check("rst.pc", pc, 32'd0);
        check("rst.pc4", pc_plus4, 32'd4);
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.instr", instr, 32'h0000_0013);
        check("rst.opc", 32'(opcode), 32'h13);
        check("rst.rd", 32'(rd), 32'd0);
        check("rst.f7", 32'(funct7), 32'd0);
        check("rst.cnt", fetch_count, 32'd0);
        check("rst.flt", 32'(fetch_fault), 32'd0);
        rst = 1'b0;
        #1;

        do_fetch("zw", 0, 32'h0050_0093, 0, 1'b0, 32'd0);
        check("zw.addr", imem_addr, 32'd4);
        check("zw.cnt", fetch_count, 32'd1);

        do_fetch("ws", 3, $urandom, 0, 1'b0, 32'd0);
        do_fetch("bp", 0, $urandom, 5, 1'b0, 32'd0);

        do_fetch("br", 1, $urandom, 1, 1'b1, 32'h0000_0040);
        check("br.addr", imem_addr, 32'h40);
        do_fetch("br2", 0, $urandom, 0, 1'b0, 32'd0);

        do_fetch("wr", 0, $urandom, 0, 1'b1, 32'hFFFF_FFFC);
        do_fetch("wr2", 0, $urandom, 0, 1'b0, 32'd0);
        check("wr.addr", imem_addr, 32'd0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] t;
            t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            t[1:0] = 2'b00;
`endif
            do_fetch("rnd", int'($urandom_range(0, 3)), $urandom,
                     int'($urandom_range(0, 3)), 1'($urandom), t);
        end

        chk_req("mr.pre");
        step();
        chk_req("mr.pre2");
        rst = 1'b1;
        #1;
        check("mr.req", 32'(imem_req), 32'd0);
        check("mr.pc", pc, 32'd0);
        check("mr.instr", instr, 32'h0000_0013);
        check("mr.cnt", fetch_count, 32'd0);
        step();
        rst = 1'b0;
        #1;
        m_pc  = 32'd0;
        m_cnt = 32'd0;
        m_ir  = 32'h0000_0013;
        do_fetch("mr.f", 1, $urandom, 0, 1'b1, 32'h0000_0100);

        do_fetch("mis", 0, $urandom, 0, 1'b1, 32'h0000_0042);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            check("halt.req", 32'(imem_req), 32'd0);
            check("halt.valid", 32'(instr_valid), 32'd0);
            check("halt.flt", 32'(fetch_fault), 32'd1);
            check("halt.pc", pc, m_pc);
            check("halt.cnt", fetch_count, m_cnt);
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom);
            step();
        end
`else
        check("mis.addr", imem_addr, 32'h0000_0040);
        do_fetch("mis2", 0, $urandom, 0, 1'b0, 32'd0);
        check("mis.flt", 32'(fetch_fault), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
